// File: rtl/pulse_burst_scheduler.sv
// pulse_burst_scheduler: programmable periodic pulse sequencer.
// Runs a modulo-period_r cycle counter under start/stop control and emits a
// one-cycle pulse at the end of each period, either for a fixed burst count or
// continuously (burst length 0).
// Optional feature macro PULSE_PAUSE_EN adds a 'pause' input that freezes the
// counter and burst count while running.
module pulse_burst_scheduler #(
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned BURST_W    = 8,
    parameter int unsigned DEF_PERIOD = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
`ifdef PULSE_PAUSE_EN
    input  logic               pause,
`endif
    output logic [CNT_W-1:0]   cnt,
    output logic               periodic_pulses,
    output logic [BURST_W-1:0] pulses_left,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] left_q, left_d;
    logic               pulse_c;
    logic               paused_c;

    // Pause qualifier: real input when the feature is built in, otherwise never paused
`ifdef PULSE_PAUSE_EN
    assign paused_c = pause;
`else
    assign paused_c = 1'b0;
`endif

    // State, counter and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= RST_PERIOD;
            burst_q  <= '0;
            left_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            burst_q  <= burst_d;
            left_q   <= left_d;
        end
    end

    // Next-state, counter, burst bookkeeping and pulse decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        burst_d  = burst_q;
        left_d   = left_q;
        pulse_c  = (state_q == RUN) && (cnt_q == period_q - CNT_W'(1)) && !paused_c;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                left_d = burst_q;
                if (cfg_we) begin
                    // Config write takes priority over a simultaneous start
                    period_d = (cfg_period < MIN_PERIOD) ? MIN_PERIOD : cfg_period;
                    burst_d  = cfg_burst;
                    left_d   = cfg_burst;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    // Abort wins over burst completion, no done strobe
                    state_d = IDLE;
                    cnt_d   = '0;
                    left_d  = burst_q;
                end else if (!paused_c) begin
                    if (pulse_c) begin
                        cnt_d = '0;
                        if (burst_q != '0) begin
                            if (left_q == BURST_W'(1)) begin
                                state_d = DONE;
                                left_d  = '0;
                            end else begin
                                left_d = left_q - BURST_W'(1);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                left_d  = burst_q;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                left_d  = '0;
            end
        endcase
    end

    assign cnt             = cnt_q;
    assign pulses_left     = left_q;
    assign periodic_pulses = pulse_c;
    assign busy            = (state_q == RUN);
    assign done            = (state_q == DONE);

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Directed self-checking bench for pulse_burst_scheduler.
module tb_pulse_burst_scheduler;

    localparam int unsigned CNT_W   = 5;
    localparam int unsigned BURST_W = 8;

    logic               clk;
    logic               rst_n;
    logic               cfg_we;
    logic [CNT_W-1:0]   cfg_period;
    logic [BURST_W-1:0] cfg_burst;
    logic               start;
    logic               stop;
    logic               pause;
    logic [CNT_W-1:0]   cnt;
    logic               periodic_pulses;
    logic [BURST_W-1:0] pulses_left;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;

    pulse_burst_scheduler #(
        .CNT_W(CNT_W),
        .BURST_W(BURST_W),
        .DEF_PERIOD(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_we(cfg_we),
        .cfg_period(cfg_period),
        .cfg_burst(cfg_burst),
        .start(start),
        .stop(stop),
`ifdef PULSE_PAUSE_EN
        .pause(pause),
`endif
        .cnt(cnt),
        .periodic_pulses(periodic_pulses),
        .pulses_left(pulses_left),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle config write
    task automatic write_cfg(input int p, input int b);
        cfg_we     = 1'b1;
        cfg_period = CNT_W'(p);
        cfg_burst  = BURST_W'(b);
        step();
        cfg_we     = 1'b0;
    endtask

    // Issue a one-cycle start; returns with the first RUN cycle sampled
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        int k;
        bit seen;
        #2;
        checks++;
        if (cnt !== 0 || busy !== 1'b0 || done !== 1'b0 || pulses_left !== 0 || periodic_pulses !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d busy=%b done=%b left=%0d pulse=%b, expected all 0",
                     cnt, busy, done, pulses_left, periodic_pulses);
        end
        #10 rst_n = 1'b1;
        step();
        // Dirty the configuration, then reset mid-run
        write_cfg(7, 4);
        do_start();
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cnt !== 0 || busy !== 1'b0 || periodic_pulses !== 1'b0 || pulses_left !== 0) begin
            errors++;
            $display("FAIL midrun_reset: cnt=%0d busy=%b pulse=%b left=%0d, expected 0 0 0 0",
                     cnt, busy, periodic_pulses, pulses_left);
        end
        #1 rst_n = 1'b1;
        step();
        // Default period must be back: first pulse on the 20th RUN cycle
        do_start();
        k = 1;
        seen = 0;
        while (k <= 60 && !seen) begin
            if (periodic_pulses === 1'b1) seen = 1;
            else begin
                step();
                k++;
            end
        end
        checks++;
        if (!seen || k != 20) begin
            errors++;
            $display("FAIL default_period: first pulse at cycle %0d (seen=%0d), expected 20", k, seen);
        end
        do_stop();
    endtask

    task automatic test_continuous();
        int npulse;
        int bad;
        npulse = 0;
        bad = 0;
        do_start();
        for (int k = 1; k <= 100; k++) begin
            if (periodic_pulses === 1'b1) npulse++;
            if (periodic_pulses !== ((k % 20) == 0) || cnt !== CNT_W'((k - 1) % 20) ||
                done !== 1'b0 || pulses_left !== 0 || busy !== 1'b1) bad++;
            step();
        end
        checks++;
        if (npulse != 5) begin
            errors++;
            $display("FAIL continuous_count: got %0d pulses, expected 5", npulse);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL continuous_trace: %0d bad cycles, expected 0", bad);
        end
        do_stop();
        checks++;
        if (busy !== 1'b0 || cnt !== 0) begin
            errors++;
            $display("FAIL continuous_stop: busy=%b cnt=%0d, expected 0 0", busy, cnt);
        end
    endtask

    task automatic test_burst();
        int exp_left;
        write_cfg(5, 3);
        checks++;
        if (pulses_left !== 3) begin
            errors++;
            $display("FAIL burst_cfg_follow: left=%0d, expected 3", pulses_left);
        end
        do_start();
        for (int k = 1; k <= 17; k++) begin
            exp_left = (k <= 5) ? 3 : (k <= 10) ? 2 : (k <= 15) ? 1 : (k == 16) ? 0 : 3;
            checks++;
            if (periodic_pulses !== (k == 5 || k == 10 || k == 15) || done !== (k == 16) ||
                busy !== (k < 16) || pulses_left !== BURST_W'(exp_left)) begin
                errors++;
                $display("FAIL burst_cycle%0d: pulse=%b done=%b busy=%b left=%0d, expected %b %b %b %0d",
                         k, periodic_pulses, done, busy, pulses_left,
                         (k == 5 || k == 10 || k == 15), (k == 16), (k < 16), exp_left);
            end
            step();
        end
    endtask

    task automatic test_clamp();
        write_cfg(1, 0);
        do_start();
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (periodic_pulses !== ((k % 2) == 0)) begin
                errors++;
                $display("FAIL clamp_cycle%0d: pulse=%b, expected %b", k, periodic_pulses, ((k % 2) == 0));
            end
            // Config write during RUN must be ignored
            if (k == 6) begin
                write_cfg(9, 0);
            end else begin
                step();
            end
        end
        do_stop();
    endtask

    task automatic test_stop_on_pulse();
        write_cfg(4, 2);
        do_start();
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (periodic_pulses !== (k == 4 || k == 8)) begin
                errors++;
                $display("FAIL stop_trace%0d: pulse=%b, expected %b", k, periodic_pulses, (k == 4 || k == 8));
            end
            if (k < 8) step();
        end
        do_stop();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pulses_left !== 2 || cnt !== 0) begin
            errors++;
            $display("FAIL stop_on_pulse: busy=%b done=%b left=%0d cnt=%0d, expected 0 0 2 0",
                     busy, done, pulses_left, cnt);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cnt !== 0) begin
            errors++;
            $display("FAIL stop_idle: done=%b busy=%b cnt=%0d, expected 0 0 0", done, busy, cnt);
        end
    endtask

`ifdef PULSE_PAUSE_EN
    task automatic test_pause();
        write_cfg(6, 0);
        do_start();
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (periodic_pulses !== (k == 10) || busy !== 1'b1 ||
                cnt !== CNT_W'((k <= 4) ? k - 1 : (k <= 8) ? 3 : k - 5)) begin
                errors++;
                $display("FAIL pause_cycle%0d: pulse=%b busy=%b cnt=%0d", k, periodic_pulses, busy, cnt);
            end
            if (k == 4) pause = 1'b1;
            if (k == 8) pause = 1'b0;
            step();
        end
        do_stop();
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        cfg_we     = 1'b0;
        cfg_period = '0;
        cfg_burst  = '0;
        start      = 1'b0;
        stop       = 1'b0;
        pause      = 1'b0;
        test_reset();
        test_continuous();
        test_burst();
        test_clamp();
        test_stop_on_pulse();
`ifdef PULSE_PAUSE_EN
        test_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
